// File: rtl/eth_tx_pkg.sv
// Shared definitions for the Ethernet TX arbiter: state encoding, default size width, minimum payload.
package eth_tx_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ARB       = 3'd1;
  localparam logic [2:0] ST_START     = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;
  localparam logic [2:0] ST_ERR       = 3'd5;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    ARB       = ST_ARB,
    START     = ST_START,
    WAIT_DONE = ST_WAIT_DONE,
    DONE      = ST_DONE,
    ERR       = ST_ERR
  } state_t;

  localparam int SIZE_W_DEF  = 16;
  // The transmitter pads shorter payloads up to this length; the arbiter passes sizes through untouched.
  localparam int MIN_PAYLOAD = 60;

endpackage

// File: rtl/eth_tx_arbiter_if.sv
// Requester and transmitter signal bundle for eth_tx_arbiter; slave is the arbiter's view.
interface eth_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int SIZE_W  = eth_tx_pkg::SIZE_W_DEF
);
  // Requesters hold i_req (level) and their descriptor until o_done or o_err pulses for
  // them; the arbiter drives o_tx_start as a level that stays high until i_tx_busy is seen.
  logic [NUM_REQ-1:0]        i_req;
  logic [NUM_REQ*SIZE_W-1:0] i_req_size;
  logic [NUM_REQ-1:0]        i_req_lfsr;
  logic [7:0]                i_gap_count;
  logic                      i_tx_busy;
  logic                      o_tx_start;
  logic [SIZE_W-1:0]         o_tx_size;
  logic                      o_tx_lfsr_enable;
  logic [7:0]                o_gap_count;
  logic [NUM_REQ-1:0]        o_grant;
  logic [NUM_REQ-1:0]        o_done;
  logic [NUM_REQ-1:0]        o_err;
  logic                      o_active;

  modport slave (
    input  i_req, i_req_size, i_req_lfsr, i_gap_count, i_tx_busy,
    output o_tx_start, o_tx_size, o_tx_lfsr_enable, o_gap_count,
           o_grant, o_done, o_err, o_active
  );

  modport master (
    output i_req, i_req_size, i_req_lfsr, i_gap_count, i_tx_busy,
    input  o_tx_start, o_tx_size, o_tx_lfsr_enable, o_gap_count,
           o_grant, o_done, o_err, o_active
  );
endinterface

// File: rtl/eth_tx_rr_picker.sv
// One-hot winner selection: round robin from i_ptr, or fixed lowest-index priority
// when ETH_TX_ARB_FIXED_PRIO_EN is defined.
module eth_tx_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant
);

  logic w_found;

`ifdef ETH_TX_ARB_FIXED_PRIO_EN
  logic w_unused_ptr;
  assign w_unused_ptr = ^i_ptr;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && i_req[k]) begin
        o_grant[k] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end
`else
  int w_idx;

  // Search upward from the pointer, wrapping at NUM_REQ.
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (int'(i_ptr) + k) % NUM_REQ;
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/eth_tx_arbiter.sv
// Shares one eth_tx_fsm transmit path among NUM_REQ frame requesters.
// Build option ETH_TX_ARB_FIXED_PRIO_EN selects fixed priority instead of round robin.
module eth_tx_arbiter
  import eth_tx_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int SIZE_W        = SIZE_W_DEF,
  parameter int START_TIMEOUT = 64,
  parameter int COOLDOWN      = 4
) (
  input  logic               i_eth_clk,
  input  logic               i_rst,
  eth_tx_arbiter_if.slave    bus,
  output state_t             o_state
);

  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int CNT_W  = $clog2(START_TIMEOUT + 1);
  localparam int COOL_W = $clog2(COOLDOWN + 1);

  state_t             r_state;
  state_t             w_next;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_win;
  logic [PTR_W-1:0]   w_pick_idx;
  logic [NUM_REQ-1:0] w_pick;
  logic [NUM_REQ-1:0] r_grant;
  logic [CNT_W-1:0]   r_cnt;
  logic [COOL_W-1:0]  r_cool;
  logic [SIZE_W-1:0]  r_size;
  logic               r_lfsr;
  logic [7:0]         r_gap;

  eth_tx_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .i_req   (bus.i_req),
    .i_ptr   (r_ptr),
    .o_grant (w_pick)
  );

  always_comb begin
    w_pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick[i]) w_pick_idx = PTR_W'(i);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        // A busy transmitter (including PLL unlocked) blocks any new grant.
        if ((|bus.i_req) && !bus.i_tx_busy && (r_cool == '0)) w_next = ARB;
      end
      ARB: begin
        if (|w_pick) w_next = START;
        else         w_next = IDLE;
      end
      START: begin
        if (bus.i_tx_busy)                              w_next = WAIT_DONE;
        else if (r_cnt == CNT_W'(START_TIMEOUT - 1))    w_next = ERR;
      end
      WAIT_DONE: begin
        if (!bus.i_tx_busy) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      ERR:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_eth_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_win   <= '0;
      r_grant <= '0;
      r_cnt   <= '0;
      r_cool  <= '0;
      r_size  <= '0;
      r_lfsr  <= 1'b0;
      r_gap   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (r_cool != '0) r_cool <= r_cool - 1'b1;
        end
        ARB: begin
          if (|w_pick) begin
            r_win   <= w_pick_idx;
            r_grant <= w_pick;
            r_size  <= bus.i_req_size[w_pick_idx*SIZE_W +: SIZE_W];
            r_lfsr  <= bus.i_req_lfsr[w_pick_idx];
            r_gap   <= bus.i_gap_count;
          end
          r_cnt <= '0;
        end
        START: r_cnt <= r_cnt + 1'b1;
        DONE, ERR: begin
          r_grant <= '0;
          r_ptr   <= (r_win == PTR_W'(NUM_REQ - 1)) ? '0 : r_win + 1'b1;
          r_cool  <= COOL_W'(COOLDOWN);
        end
        default: ;
      endcase
    end
  end

  // Grant stays set through DONE/ERR so the completion pulse lands on the owner.
  assign bus.o_tx_start       = (r_state == START);
  assign bus.o_tx_size        = r_size;
  assign bus.o_tx_lfsr_enable = r_lfsr;
  assign bus.o_gap_count      = r_gap;
  assign bus.o_grant          = r_grant;
  assign bus.o_done           = (r_state == DONE) ? r_grant : '0;
  assign bus.o_err            = (r_state == ERR)  ? r_grant : '0;
  assign bus.o_active         = (r_state != IDLE);
  assign o_state              = r_state;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Scoreboard bench for eth_tx_arbiter: directed frames, a busy model and an event monitor.
module tb_eth_tx_arbiter;
  import eth_tx_pkg::*;

  localparam int N  = 4;
  localparam int SW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  eth_tx_arbiter_if #(.NUM_REQ(N), .SIZE_W(SW)) bus();
  state_t dbg_state;

  eth_tx_arbiter #(
    .NUM_REQ(N), .SIZE_W(SW), .START_TIMEOUT(64), .COOLDOWN(4)
  ) dut (
    .i_eth_clk (clk),
    .i_rst     (rst),
    .bus       (bus),
    .o_state   (dbg_state)
  );

  logic [15:0] sizes [N];
  logic [3:0]  lfsr_tbl;
  logic [7:0]  gap;
  logic        model_en;
  logic        model_busy;
  logic        force_busy;
  int          busy_len;
  int          exp_hi_len;

  assign bus.i_req_size  = {sizes[3], sizes[2], sizes[1], sizes[0]};
  assign bus.i_req_lfsr  = lfsr_tbl;
  assign bus.i_gap_count = gap;
  assign bus.i_tx_busy   = model_busy | force_busy;

  int          n_cmp = 0;
  int          n_mis = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Event word: {2'b0, kind[1:0], idx[2:0], lfsr, gap[7:0], size[15:0]}; kind 0=start 1=done 2=err
  function automatic logic [31:0] ev(input logic [1:0] kind, input int idx, input logic l,
                                     input logic [7:0] g, input logic [15:0] s);
    logic [2:0] i3;
    i3 = 3'(idx);
    return {2'b00, kind, i3, l, g, s};
  endfunction

  task automatic push_frame(input int k, input bit timeout);
    exp_q.push_back(ev(2'd0, k, lfsr_tbl[k], gap, sizes[k]));
    exp_q.push_back(ev(timeout ? 2'd2 : 2'd1, k, lfsr_tbl[k], gap, sizes[k]));
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    int r;
    r = 7;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic compare_event(input logic [1:0] kind, input logic [N-1:0] vec);
    logic [31:0] act;
    check("event_onehot", 32'($onehot(vec)), 32'd1);
    act = ev(kind, oh_idx(vec), bus.o_tx_lfsr_enable, bus.o_gap_count, bus.o_tx_size);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL unexpected_event: got %0h, want no event (t=%0t)", act, $time);
    end else begin
      check("event", act, exp_q.pop_front());
    end
  endtask

  // Monitor: start rise/fall, pulse widths, gaps and completion pulses.
  logic prev_start = 1'b0;
  logic seen_start = 1'b0;
  int   hi_len = 0;
  int   lo_len = 0;
  int   n_starts = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_start = 1'b0;
    end else begin
      if (bus.o_tx_start) begin
        if (!prev_start) begin
          n_starts++;
          if (seen_start) check("start_gap_ge_cooldown", 32'(lo_len >= 4), 32'd1);
          seen_start = 1'b1;
          hi_len = 0;
          compare_event(2'd0, bus.o_grant);
        end
        hi_len++;
      end else begin
        if (prev_start) begin
          check("start_width", 32'(hi_len), 32'(exp_hi_len));
          lo_len = 0;
        end
        lo_len++;
      end
      if (|bus.o_done) compare_event(2'd1, bus.o_done);
      if (|bus.o_err)  compare_event(2'd2, bus.o_err);
      prev_start = bus.o_tx_start;
    end
  end

  // Transmitter model: busy rises a fixed delay after start and holds for busy_len cycles.
  initial begin
    model_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (model_en && bus.o_tx_start && !model_busy && !force_busy) begin
        repeat (2) @(posedge clk);
        #1 model_busy = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1 model_busy = 1'b0;
      end
    end
  end

  task automatic wait_drain(input int budget);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      @(posedge clk);
      c++;
    end
    check("drain_outstanding", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic wait_starts(input int target, input int budget);
    int c;
    c = 0;
    while (n_starts < target && c < budget) begin
      @(posedge clk);
      c++;
    end
    check("start_count", 32'(n_starts), 32'(target));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_start"},  32'(bus.o_tx_start), 32'd0);
    check({tag, "_grant"},  32'(bus.o_grant), 32'd0);
    check({tag, "_done"},   32'(bus.o_done), 32'd0);
    check({tag, "_err"},    32'(bus.o_err), 32'd0);
    check({tag, "_active"}, 32'(bus.o_active), 32'd0);
    check({tag, "_size"},   32'(bus.o_tx_size), 32'd0);
    check({tag, "_lfsr"},   32'(bus.o_tx_lfsr_enable), 32'd0);
    check({tag, "_gap"},    32'(bus.o_gap_count), 32'd0);
    check({tag, "_state"},  32'(dbg_state), 32'(IDLE));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int c;
    rst        = 1'b1;
    bus.i_req  = '0;
    sizes[0]   = 16'd64;
    sizes[1]   = 16'd1500;
    sizes[2]   = 16'd100;
    sizes[3]   = 16'd0;
    lfsr_tbl   = 4'b1010;
    gap        = 8'd12;
    model_en   = 1'b0;
    force_busy = 1'b0;
    busy_len   = 20;
    exp_hi_len = 3;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Round robin from pointer 0 with all four requesting
    model_en = 1'b1;
    push_frame(0, 0); push_frame(1, 0); push_frame(2, 0); push_frame(3, 0); push_frame(0, 0);
    @(posedge clk);
    #1 bus.i_req = 4'b1111;
    wait_starts(5, 3000);
    @(posedge clk);
    #1 bus.i_req = 4'b0000;
    wait_drain(500);

    // Single request: latency, latched descriptor, long busy
    repeat (10) @(posedge clk);
    busy_len = 200;
    gap      = 8'd96;
    push_frame(2, 0);
    @(posedge clk);
    #1 bus.i_req = 4'b0100;
    @(posedge clk);
    @(negedge clk);
    check("lat_arb_start_low", 32'(bus.o_tx_start), 32'd0);
    check("lat_arb_state", 32'(dbg_state), 32'(ARB));
    @(posedge clk);
    @(negedge clk);
    check("lat_start_high", 32'(bus.o_tx_start), 32'd1);
    check("single_grant", 32'(bus.o_grant), 32'b0100);
    check("single_size", 32'(bus.o_tx_size), 32'd100);
    wait_drain(600);
    #1 bus.i_req = 4'b0000;

    // Busy stuck high (PLL unlocked) at request time
    repeat (10) @(posedge clk);
    busy_len   = 20;
    gap        = 8'd12;
    force_busy = 1'b1;
    model_en   = 1'b0;
    push_frame(0, 0);
    @(posedge clk);
    #1 bus.i_req = 4'b0001;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("busy_no_grant", {30'd0, bus.o_active, |bus.o_grant}, 32'd0);
    end
    @(posedge clk);
    #1 begin force_busy = 1'b0; model_en = 1'b1; end
    @(negedge clk);
    check("busy_drop_grant_c0", 32'(bus.o_grant), 32'd0);
    @(negedge clk);
    check("busy_drop_grant_c1", 32'(bus.o_grant), 32'd0);
    @(negedge clk);
    check("busy_drop_grant_c2", 32'(bus.o_grant), 32'b0001);
    wait_drain(300);
    #1 bus.i_req = 4'b0000;

    // Reset during WAIT_DONE
    repeat (10) @(posedge clk);
    exp_q.push_back(ev(2'd0, 0, lfsr_tbl[0], gap, sizes[0]));
    @(posedge clk);
    #1 bus.i_req = 4'b0001;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (dbg_state != WAIT_DONE && c < 100);
    check("reach_wait_done", 32'(dbg_state), 32'(WAIT_DONE));
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    bus.i_req = 4'b0000;
    repeat (30) @(posedge clk);
    #1 rst = 1'b0;
    wait_drain(10);

    // Start timeout on requester 0, then requester 1 served
    repeat (5) @(posedge clk);
    model_en   = 1'b0;
    exp_hi_len = 64;
    push_frame(0, 1);
    push_frame(1, 0);
    @(posedge clk);
    #1 bus.i_req = 4'b0011;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (bus.o_err == '0 && c < 200);
    check("timeout_err", 32'(bus.o_err), 32'b0001);
    @(posedge clk);
    #1 begin bus.i_req = 4'b0010; model_en = 1'b1; exp_hi_len = 3; end
    wait_drain(300);
    #1 bus.i_req = 4'b0000;

    // Requesters 1 and 3 held together after a reset
    do_reset();
    repeat (3) @(posedge clk);
`ifdef ETH_TX_ARB_FIXED_PRIO_EN
    push_frame(1, 0); push_frame(1, 0); push_frame(1, 0);
`else
    push_frame(1, 0); push_frame(3, 0); push_frame(1, 0);
`endif
    c = n_starts;
    @(posedge clk);
    #1 bus.i_req = 4'b1010;
    wait_starts(c + 3, 1000);
    @(posedge clk);
    #1 bus.i_req = 4'b0000;
    wait_drain(300);

    repeat (10) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #500000;
    n_mis++;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/eth_tx_arbiter.md
Name: eth_tx_arbiter

Overview:
- Shares the single RGMII transmit path (eth_tx_fsm) between NUM_REQ frame requesters.
- Each requester presents a frame descriptor: payload size in bytes and an LFSR test-mode flag. The arbiter grants one requester at a time and drives the transmitter's size, LFSR-enable, gap and start inputs.
- After each frame it waits for the transmitter's busy flag to fall, then reports completion to the owning requester.
- Sits between the per-source TX buffers/packet builders and eth_tx_fsm, in the i_eth_clk domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SIZE_W, 16, descriptor size width; matches the transmitter size input.
- START_TIMEOUT, 64, cycles o_tx_start is held waiting for i_tx_busy before the frame is aborted.
- COOLDOWN, 4, minimum cycles o_tx_start stays low between start assertions; must be ≥3 for the transmitter's edge detector.

Ports:
- i_eth_clk  in  1  transmit clock; all logic is on its rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_req  in  NUM_REQ  per-requester frame request, level.
- i_req_size  in  NUM_REQ*SIZE_W  packed sizes; requester k uses bits [k*SIZE_W +: SIZE_W].
- i_req_lfsr  in  NUM_REQ  per-requester LFSR test-mode flag.
- i_gap_count  in  8  interframe gap, passed through at grant.
- i_tx_busy  in  1  transmitter busy; it is also high while the transmitter's PLL is unlocked.
- o_tx_start  out  1  start level to the transmitter.
- o_tx_size  out  SIZE_W  latched size of the granted frame.
- o_tx_lfsr_enable  out  1  latched LFSR flag of the granted frame.
- o_gap_count  out  8  latched gap count.
- o_grant  out  NUM_REQ  one-hot grant to the active requester.
- o_done  out  NUM_REQ  one-cycle completion pulse.
- o_err  out  NUM_REQ  one-cycle start-timeout pulse.
- o_active  out  1  high from ARB through DONE/ERR.

Behaviour:
- Reset values: every output is 0, the round-robin pointer is 0, the state is IDLE, and the counters are 0.
- IDLE:
  - Moves to ARB when any i_req bit is high, i_tx_busy==0, and the cooldown counter has expired.
  - While i_tx_busy==1 (e.g. PLL unlocked), no grant is issued.
- ARB (1 cycle):
  - Picks the winner by round robin: first requester with i_req set, searching from the pointer upward with wrap.
  - Latches that requester's size and LFSR flag, plus i_gap_count, into the o_tx_* outputs.
  - Sets o_grant for the winner and goes to START.
- START:
  - o_tx_start=1, and a cycle counter increments.
  - If i_tx_busy==1, go to WAIT_DONE.
  - Else if the counter reaches START_TIMEOUT-1, go to ERR.
- WAIT_DONE:
  - o_tx_start=0.
  - When i_tx_busy==0, go to DONE.
- DONE (1 cycle):
  - Pulses o_done[winner], clears o_grant, and sets pointer = winner+1 (mod NUM_REQ).
  - Loads the cooldown counter with COOLDOWN and returns to IDLE.
- ERR (1 cycle):
  - Pulses o_err[winner], clears o_grant, and advances the pointer the same way as DONE.
  - Loads the cooldown counter and returns to IDLE.
- Hold rules:
  - o_tx_size, o_tx_lfsr_enable and o_gap_count are stable from the cycle after ARB until DONE/ERR.
  - Between frames they hold their last value.
- Requester contract:
  - Hold i_req and the descriptor until o_done or o_err.
  - Dropping i_req after grant is ignored: the frame runs to completion.
  - Re-asserting i_req in the cycle after o_done is legal.
- Size 0 is passed through unchanged; the transmitter pads it to 60.
- Simultaneous requests are resolved by the pointer only. A single persistent requester is served back-to-back, separated by COOLDOWN.
- Reset mid-frame: o_tx_start and o_grant drop in the next cycle, and no o_done or o_err is issued.
- Latency: from i_req rising in IDLE (busy low, cooldown expired) to o_tx_start high is 2 cycles.

Optional Feature:
- Macro ETH_TX_ARB_FIXED_PRIO_EN.
- Defined: ARB picks the lowest-index active requester (requester 0 highest priority). The pointer is not used.
- Undefined: round robin as described above.
- All other timing is identical in both modes.

Decomposition:
- Shared package eth_tx_pkg holds:
  - the state encoding localparams (IDLE, ARB, START, WAIT_DONE, DONE, ERR);
  - the default SIZE_W of 16;
  - the minimum payload constant 60.
- One sub-module, eth_tx_rr_picker: combinational one-hot winner selection from the request vector and pointer. It is also compiled for fixed priority under the macro.

Test Plan:
- Single request:
  - Stimulus: i_req=4'b0100, size 100; busy model rises 3 cycles after start and falls after 200 cycles.
  - Response: o_grant=4'b0100, o_tx_size=100, o_tx_start high exactly until busy rises, one o_done[2] pulse.
- Round robin:
  - Stimulus: i_req=4'b1111 held.
  - Response: grant order 0,1,2,3,0. o_tx_start low for ≥4 cycles between frames.
- Busy stuck high at request (PLL unlocked):
  - Stimulus: i_req=4'b0001 with i_tx_busy held high; busy then drops.
  - Response: no grant while busy is high; grant 2 cycles after busy drops.
- Start timeout:
  - Stimulus: busy never rises.
  - Response: o_tx_start high for 64 cycles, then o_err[0] pulse; the pointer advances and the next requester is served.
- Mid-frame reset:
  - Stimulus: i_rst asserted during WAIT_DONE.
  - Response: the next cycle shows all outputs 0 and state IDLE, with no done pulse.
- Macro defined:
  - Stimulus: i_req=4'b1010 held.
  - Response: requester 1 is granted repeatedly and requester 3 is never granted.
